skid_like_mem_fifo: RTL

Parametrised, multi-entry successor of the single-register memory-side skid buffer. It sits between a pipeline producer and a delayed-RAM consumer and holds up to DEPTH words in a circular store. A same-cycle memory ACK frees a slot in the ACK'ed cycle, so input can be accepted at full rate even when the store is full. An optional zero-latency bypass forwards input straight to the memory when the store is empty.

---
 rtl/skid_like_mem_fifo_if.sv | 11 +
 rtl/skid_like_mem_fifo.sv | 107 ++++++++++
 2 files changed

// File: rtl/skid_like_mem_fifo_if.sv
// Valid/ack/data handshake bundle used on both sides of skid_like_mem_fifo.
interface data_interface #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ack;
  logic [DATA_WIDTH-1:0] data;

  modport producer (output valid, output data, input ack);
  modport consumer (input valid, input data, output ack);
endinterface

// File: rtl/skid_like_mem_fifo.sv
// Multi-entry memory-side skid FIFO: DEPTH-word circular store between a pipeline and a RAM.
// Define SKID_MEM_BYPASS_EN to enable the zero-latency in->out bypass when the store is empty.
module skid_like_mem_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int LW        = $clog2(DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset_n,
  data_interface.consumer in,
  data_interface.producer out,
  output logic [LW-1:0]   level,
  output logic            full,
  output logic            empty
);
  localparam int            PW      = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_C = LW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]         count_q, count_d;

  logic                  stored;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  in_ack_c;
  logic                  out_valid_c;
  logic [DATA_WIDTH-1:0] out_data_c;
  logic                  bypass_thru;
  logic                  accept;
  logic                  consume;
  logic                  push;
  logic                  pop;

  // Handshake outputs; all forced low while reset_n is sampled low.
  always_comb begin
    stored      = (count_q != '0);
    head_data   = mem_q[rd_ptr_q];
    in_ack_c    = reset_n && ((count_q < DEPTH_C) || out.ack);
    out_valid_c = 1'b0;
    out_data_c  = '0;
    bypass_thru = 1'b0;
    if (reset_n) begin
      if (stored) begin
        out_valid_c = 1'b1;
        out_data_c  = head_data;
      end
`ifdef SKID_MEM_BYPASS_EN
      else if (in.valid) begin
        out_valid_c = 1'b1;
        out_data_c  = in.data;
      end
      bypass_thru = !stored && in.valid && out.ack;
`endif
    end
    accept  = in.valid && in_ack_c;
    consume = out_valid_c && out.ack;
    push    = accept && !bypass_thru;
    pop     = consume && stored;
  end

  // At full, a same-cycle pop frees the slot that the push refills.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in.data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not cleared: emptied pointers make stale words unreachable.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign in.ack    = in_ack_c;
  assign out.valid = out_valid_c;
  assign out.data  = out_data_c;
  assign level     = count_q;
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);

endmodule
